// File: rtl/pong_clk_pkg.sv
// Shared types and default constants for the Pong clock/reset generator.
package pong_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        SETTLE     = 2'd1,
        RESET_HOLD = 2'd2,
        RUN        = 2'd3
    } state_t;

    localparam int unsigned LOCK_DROPS_W = 4;

    localparam int unsigned SYNC_STAGES_DEF   = 2;
    localparam int unsigned SETTLE_CYCLES_DEF = 4096;
    localparam int unsigned RESET_CYCLES_DEF  = 256;
    localparam int unsigned CE_DIV_DEF        = 8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pong_clk_rst_gen_if.sv
// Lock/reset request inputs and reset/clock-enable/status outputs of the generator.
interface pong_clk_rst_gen_if;
    import pong_clk_pkg::*;

    logic                    pll_locked;
    logic                    user_reset;
    logic                    core_reset;
    logic                    ce_pix;
    logic                    ce_half;
    logic                    running;
    logic [LOCK_DROPS_W-1:0] lock_drops;

    modport master (
        input  pll_locked,
        input  user_reset,
        output core_reset,
        output ce_pix,
        output ce_half,
        output running,
        output lock_drops
    );

    modport slave (
        output pll_locked,
        output user_reset,
        input  core_reset,
        input  ce_pix,
        input  ce_half,
        input  running,
        input  lock_drops
    );

endinterface

// File: rtl/pong_clk_rst_gen_sync.sv
// Multi-flop bit synchroniser for bringing the asynchronous PLL lock flag into clk_sys.
module pong_sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pong_clk_rst_gen.sv
// Qualifies PLL lock, sequences core reset release and generates the pixel clock-enables.
module pong_clk_rst_gen
    import pong_clk_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned RESET_CYCLES  = RESET_CYCLES_DEF,
    parameter int unsigned CE_DIV        = CE_DIV_DEF
) (
    input logic               clk_sys,
    input logic               reset,
    pong_clk_rst_gen_if.master io
);

    localparam int unsigned CNT_W = $clog2(max_u(SETTLE_CYCLES, RESET_CYCLES));
    localparam int unsigned DIV_W = $clog2(CE_DIV);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CE_DIV - 1);
    localparam logic [DIV_W-1:0] HALF_LAST   = DIV_W'(CE_DIV / 2 - 1);
    localparam logic [LOCK_DROPS_W-1:0] DROP_ONE = LOCK_DROPS_W'(1);

    logic             locked_s;
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [DIV_W-1:0] div;
    logic             drop_evt;
    logic             div_active, div_active_next;

    pong_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk_sys),
        .reset (reset),
        .d     (io.pll_locked),
        .q     (locked_s)
    );

    // Priority in every state: lock loss, then user_reset, then count expiry.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        drop_evt   = 1'b0;
        case (state)
            WAIT_LOCK: begin
                if (locked_s) state_next = SETTLE;
            end
            SETTLE: begin
                if (!locked_s)               state_next = WAIT_LOCK;
                else if (cnt == SETTLE_LAST) state_next = RESET_HOLD;
                else                         cnt_next   = cnt + CNT_ONE;
            end
            RESET_HOLD: begin
                if (!locked_s)              state_next = WAIT_LOCK;
                else if (io.user_reset)     cnt_next   = '0;
                else if (cnt == RESET_LAST) state_next = RUN;
                else                        cnt_next   = cnt + CNT_ONE;
            end
            RUN: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    drop_evt   = 1'b1;
                end else if (io.user_reset) begin
                    state_next = RESET_HOLD;
                end
            end
            default: state_next = WAIT_LOCK;
        endcase
    end

    assign div_active      = (state == RESET_HOLD) || (state == RUN);
    assign div_active_next = (state_next == RESET_HOLD) || (state_next == RUN);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Divider counts only while both current and next state keep it running, so it
    // reads 0 in every WAIT_LOCK/SETTLE cycle and keeps phase across RUN<->RESET_HOLD.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div        <= '0;
            io.ce_pix  <= 1'b0;
            io.ce_half <= 1'b0;
        end else if (div_active && div_active_next) begin
            div        <= (div == DIV_LAST) ? '0 : div + DIV_ONE;
            io.ce_pix  <= (div == DIV_LAST);
            io.ce_half <= (div == HALF_LAST);
        end else begin
            div        <= '0;
            io.ce_pix  <= 1'b0;
            io.ce_half <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            io.core_reset <= 1'b1;
            io.running    <= 1'b0;
        end else begin
            io.core_reset <= (state_next != RUN);
            io.running    <= (state_next == RUN);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            io.lock_drops <= '0;
        end else if (drop_evt && (io.lock_drops != '1)) begin
            io.lock_drops <= io.lock_drops + DROP_ONE;
        end
    end

endmodule

// File: tb/tb_pong_clk_rst_gen.sv
// Directed bench for pong_clk_rst_gen with short settle/reset periods.
module tb_pong_clk_rst_gen;
    import pong_clk_pkg::*;

    localparam int unsigned P_SYNC   = 2;
    localparam int unsigned P_SETTLE = 16;
    localparam int unsigned P_RESET  = 8;
    localparam int unsigned P_DIV    = 8;

    logic clk_sys = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    int   k     = 0;

    pong_clk_rst_gen_if bus ();

    pong_clk_rst_gen #(
        .SYNC_STAGES   (P_SYNC),
        .SETTLE_CYCLES (P_SETTLE),
        .RESET_CYCLES  (P_RESET),
        .CE_DIV        (P_DIV)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .io      (bus)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // k counts cycles since the last ce_pix; ce_on=0 means enables must be silent.
    task automatic step_check(input int n, input logic exp_rst, input logic ce_on, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            k++;
            chk({tag, "_core_reset"}, bus.core_reset, exp_rst);
            chk({tag, "_running"}, bus.running, !exp_rst);
            chk({tag, "_ce_pix"}, bus.ce_pix, ce_on && (k % P_DIV == 0));
            chk({tag, "_ce_half"}, bus.ce_half, ce_on && (k % P_DIV == P_DIV / 2));
        end
    endtask

    // First edge sampling pll_locked=1 is i=1: SETTLE at i=3, RESET_HOLD at i=19,
    // first ce_half at i=23, RUN with first ce_pix at i=27.
    task automatic relock(input string tag);
        for (int i = 1; i <= 26; i++) begin
            tick();
            chk({tag, "_hold_core_reset"}, bus.core_reset, 1'b1);
            chk({tag, "_hold_running"}, bus.running, 1'b0);
            chk({tag, "_hold_ce_pix"}, bus.ce_pix, 1'b0);
            chk({tag, "_hold_ce_half"}, bus.ce_half, i == 23);
        end
        tick();
        chk({tag, "_rel_core_reset"}, bus.core_reset, 1'b0);
        chk({tag, "_rel_running"}, bus.running, 1'b1);
        chk({tag, "_rel_ce_pix"}, bus.ce_pix, 1'b1);
        chk({tag, "_rel_ce_half"}, bus.ce_half, 1'b0);
        k = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        bus.pll_locked = 1'b1;
        bus.user_reset = 1'b0;

        // 1: power-up
        for (int i = 0; i < 4; i++) tick();
        chk("rst_core_reset", bus.core_reset, 1'b1);
        chk("rst_ce_pix", bus.ce_pix, 1'b0);
        chk("rst_ce_half", bus.ce_half, 1'b0);
        chk("rst_running", bus.running, 1'b0);
        chk("rst_lock_drops", bus.lock_drops, 8'd0);
        reset = 1'b0;
        relock("pwrup");
        step_check(20, 1'b0, 1'b1, "pwrup_run");

        // 4: user_reset in RUN, divider phase unaffected
        bus.user_reset = 1'b1;
        step_check(20, 1'b1, 1'b1, "usr_hold");
        bus.user_reset = 1'b0;
        step_check(7, 1'b1, 1'b1, "usr_tail");
        step_check(1, 1'b0, 1'b1, "usr_release");
        step_check(12, 1'b0, 1'b1, "usr_run");
        chk("usr_lock_drops", bus.lock_drops, 8'd0);

        // 3: lock loss in RUN
        bus.pll_locked = 1'b0;
        step_check(2, 1'b0, 1'b1, "loss_sync");
        step_check(1, 1'b1, 1'b0, "loss_drop");
        chk("loss_lock_drops", bus.lock_drops, 8'd1);
        step_check(5, 1'b1, 1'b0, "loss_wait");
        bus.pll_locked = 1'b1;
        relock("loss_relock");
        step_check(12, 1'b0, 1'b1, "loss_run");

        // 5: saturation; drop #2 coincides with user_reset
        for (int d = 2; d <= 17; d++) begin
            bus.pll_locked = 1'b0;
            step_check(2, 1'b0, 1'b1, "sat_sync");
            if (d == 2) bus.user_reset = 1'b1;
            step_check(1, 1'b1, 1'b0, "sat_drop");
            bus.user_reset = 1'b0;
            chk("sat_lock_drops", bus.lock_drops, (d > 15) ? 8'd15 : 8'(d));
            step_check(3, 1'b1, 1'b0, "sat_wait");
            bus.pll_locked = 1'b1;
            relock("sat_relock");
        end
        chk("sat_final", bus.lock_drops, 8'd15);

        // 6: reset while in RESET_HOLD
        step_check(4, 1'b0, 1'b1, "rh_run");
        bus.user_reset = 1'b1;
        step_check(3, 1'b1, 1'b1, "rh_hold");
        reset = 1'b1;
        tick();
        chk("rh_rst_core_reset", bus.core_reset, 1'b1);
        chk("rh_rst_ce_pix", bus.ce_pix, 1'b0);
        chk("rh_rst_ce_half", bus.ce_half, 1'b0);
        chk("rh_rst_running", bus.running, 1'b0);
        chk("rh_rst_lock_drops", bus.lock_drops, 8'd0);
        reset          = 1'b0;
        bus.user_reset = 1'b0;

        // 2: lock bounce while settling (locked_s low while SETTLE cnt=10)
        step_check(11, 1'b1, 1'b0, "bounce_pre");
        bus.pll_locked = 1'b0;
        step_check(3, 1'b1, 1'b0, "bounce_low");
        bus.pll_locked = 1'b1;
        relock("bounce_relock");
        step_check(8, 1'b0, 1'b1, "bounce_run");
        chk("bounce_lock_drops", bus.lock_drops, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
